// File: rtl/sequenciador_notas_param.sv
// Parametrised note sequencer: records key presses with beat durations,
// plays them back, and grades the player against them in training mode.
module sequenciador_notas_param #(
    parameter int NUM_TECLAS    = 12,
    parameter int DEPTH         = 32,
    parameter int TEMPO_W       = 4,
    parameter int TIMEOUT_BEATS = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int NW = $clog2(NUM_TECLAS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            modo,
    input  logic                  iniciar,
    input  logic                  parar,
    input  logic                  pulso_metro,
    input  logic [NUM_TECLAS-1:0] botoes,
    output logic [NUM_TECLAS-1:0] leds,
    output logic [NW-1:0]         nota_out,
    output logic                  toca,
    output logic                  acerto,
    output logic                  erro,
    output logic                  ocupado,
    output logic                  fim,
    output logic [AW:0]           num_notas,
    output logic [AW-1:0]         endereco
);

    localparam int MW  = NW + TEMPO_W;
    localparam int TBW = $clog2(TIMEOUT_BEATS + 1);
    localparam int CW  = (TEMPO_W > TBW) ? TEMPO_W : TBW;

    localparam logic [TEMPO_W-1:0] DUR_MAX = {TEMPO_W{1'b1}};
    localparam logic [AW:0]        DEPTH_N = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0]      TMO     = CW'(TIMEOUT_BEATS);

    typedef enum logic [2:0] {
        OCIOSO,
        G_ESPERA,
        G_NOTA,
        T_LE,
        T_TOCA,
        T_ESPERA,
        FIM
    } estado_t;

    estado_t            r_estado;
    logic [1:0]         r_modo;
    logic               r_any_prev;
    logic [NW-1:0]      r_code;
    logic [TEMPO_W-1:0] r_dur;
    logic [CW-1:0]      r_cnt;
    logic [AW-1:0]      r_addr;
    logic [AW:0]        r_num;
    logic               r_acerto;
    logic               r_erro;
    logic [MW-1:0]      r_rdata;
    logic [MW-1:0]      r_mem [DEPTH];

    logic [NW-1:0]      w_code;
    logic               w_any;
    logic               w_press;
    logic [TEMPO_W-1:0] w_dur_inc;
    logic [TEMPO_W-1:0] w_dur_nx;
    logic [TEMPO_W-1:0] w_dur_wr;
    logic               w_we;
    logic [MW-1:0]      w_wdata;
    logic [NW-1:0]      w_rd_code;
    logic [TEMPO_W-1:0] w_rd_dur;
    logic               w_last;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_start;
    logic [NW-1:0]      w_show;

    // Lowest-index key wins when several are held.
    always_comb begin
        w_code = '0;
        for (int i = NUM_TECLAS - 1; i >= 0; i--) begin
            if (botoes[i]) w_code = NW'(i + 1);
        end
    end

    assign w_any     = |botoes;
    assign w_press   = w_any & ~r_any_prev;
    assign w_dur_inc = (r_dur == DUR_MAX) ? r_dur : r_dur + 1'b1;
    assign w_dur_nx  = pulso_metro ? w_dur_inc : r_dur;
    assign w_dur_wr  = (w_dur_nx == '0) ? TEMPO_W'(1) : w_dur_nx;
    assign w_we      = (r_estado == G_NOTA) && !w_any && !parar;
    assign w_wdata   = {r_code, w_dur_wr};
    assign w_rd_code = r_rdata[MW-1:TEMPO_W];
    assign w_rd_dur  = r_rdata[TEMPO_W-1:0];
    assign w_last    = ((AW + 1)'(r_addr) == r_num - 1'b1);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_start   = iniciar && !parar &&
                       (r_estado == OCIOSO || r_estado == FIM);

    always_ff @(posedge clock) begin
        if (w_we) r_mem[r_addr] <= w_wdata;
        r_rdata <= r_mem[r_addr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= OCIOSO;
            r_modo     <= 2'b00;
            r_any_prev <= 1'b0;
            r_code     <= '0;
            r_dur      <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_num      <= '0;
            r_acerto   <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_any_prev <= w_any;
            r_acerto   <= 1'b0;
            r_erro     <= 1'b0;
            if (parar) begin
                r_estado <= OCIOSO;
            end else if (w_start) begin
                r_modo <= modo;
                r_addr <= '0;
                r_cnt  <= '0;
                case (modo)
                    2'b01: begin
                        r_num    <= '0;
                        r_estado <= G_ESPERA;
                    end
                    2'b10, 2'b11: r_estado <= (r_num == '0) ? FIM : T_LE;
                    default:      r_estado <= OCIOSO;
                endcase
            end else begin
                case (r_estado)
                    G_ESPERA: begin
                        if (w_press) begin
                            r_code   <= w_code;
                            r_dur    <= pulso_metro ? TEMPO_W'(1) : '0;
                            r_estado <= G_NOTA;
                        end
                    end
                    G_NOTA: begin
                        if (!w_any) begin
                            r_addr   <= r_addr + 1'b1;
                            r_num    <= r_num + 1'b1;
                            r_estado <= (r_num + 1'b1 == DEPTH_N) ? FIM : G_ESPERA;
                        end else begin
                            r_dur <= w_dur_nx;
                        end
                    end
                    T_LE: begin
                        r_cnt    <= '0;
                        r_estado <= (r_modo == 2'b11) ? T_ESPERA : T_TOCA;
                    end
                    T_TOCA: begin
                        if (pulso_metro) begin
                            if (w_cnt_inc == CW'(w_rd_dur)) begin
                                r_cnt <= '0;
                                if (w_last) begin
                                    r_estado <= FIM;
                                end else begin
                                    r_addr   <= r_addr + 1'b1;
                                    r_estado <= T_LE;
                                end
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    T_ESPERA: begin
                        if (w_press) begin
                            r_cnt <= '0;
                            if (w_code == w_rd_code) begin
                                r_acerto <= 1'b1;
                                if (w_last) begin
                                    r_estado <= FIM;
                                end else begin
                                    r_addr   <= r_addr + 1'b1;
                                    r_estado <= T_LE;
                                end
                            end else begin
                                r_erro <= 1'b1;
                            end
                        end else if (pulso_metro) begin
                            if (w_cnt_inc == TMO) begin
                                r_erro   <= 1'b1;
                                r_estado <= FIM;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Note shown: held key while recording, memory entry while replaying.
    always_comb begin
        case (r_estado)
            G_NOTA:           w_show = r_code;
            T_TOCA, T_ESPERA: w_show = w_rd_code;
            default:          w_show = '0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_TECLAS; i++) begin
            leds[i] = (w_show == NW'(i + 1));
        end
    end

    assign nota_out  = w_show;
    assign toca      = (r_estado == T_TOCA);
    assign acerto    = r_acerto;
    assign erro      = r_erro;
    assign ocupado   = (r_estado != OCIOSO) && (r_estado != FIM);
    assign fim       = (r_estado == FIM);
    assign num_notas = r_num;
    assign endereco  = r_addr;

endmodule

// File: tb/tb_sequenciador_notas_param.sv
// Directed bench for sequenciador_notas_param: record, playback,
// training, timeout, duration saturation, abort and reset.
module tb_sequenciador_notas_param;

    logic        clock;
    logic        reset;
    logic [1:0]  modo;
    logic        iniciar;
    logic        parar;
    logic        pulso_metro;
    logic [11:0] botoes;
    logic [11:0] leds;
    logic [3:0]  nota_out;
    logic        toca;
    logic        acerto;
    logic        erro;
    logic        ocupado;
    logic        fim;
    logic [5:0]  num_notas;
    logic [4:0]  endereco;

    int errors = 0;
    int checks = 0;

    sequenciador_notas_param dut (
        .clock      (clock),
        .reset      (reset),
        .modo       (modo),
        .iniciar    (iniciar),
        .parar      (parar),
        .pulso_metro(pulso_metro),
        .botoes     (botoes),
        .leds       (leds),
        .nota_out   (nota_out),
        .toca       (toca),
        .acerto     (acerto),
        .erro       (erro),
        .ocupado    (ocupado),
        .fim        (fim),
        .num_notas  (num_notas),
        .endereco   (endereco)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [1:0] m);
        modo = m;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
    endtask

    task automatic beat();
        pulso_metro = 1'b1;
        step();
        pulso_metro = 1'b0;
    endtask

    task automatic key(input int k);
        botoes = 12'(1) << k;
        step();
    endtask

    task automatic release_all();
        botoes = '0;
        step();
    endtask

    task automatic stop();
        parar = 1'b1;
        step();
        parar = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) step();
        checks++;
        if ({leds, nota_out, toca, acerto, erro, ocupado, fim} !== '0) begin
            $display("FAIL reset_outs leds=%h nota=%0d flags=%b exp 0", leds, nota_out,
                     {toca, acerto, erro, ocupado, fim});
            errors++;
        end
        checks++;
        if (num_notas !== 6'd0 || endereco !== 5'd0) begin
            $display("FAIL reset_cnt num=%0d addr=%0d exp 0/0", num_notas, endereco);
            errors++;
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_parar_priority();
        modo = 2'b01;
        iniciar = 1'b1;
        parar = 1'b1;
        step();
        iniciar = 1'b0;
        parar = 1'b0;
        checks++;
        if (ocupado !== 1'b0 || fim !== 1'b0) begin
            $display("FAIL parar_prio ocupado=%b fim=%b exp 0/0", ocupado, fim);
            errors++;
        end
    endtask

    task automatic test_record();
        start(2'b01);
        checks++;
        if (ocupado !== 1'b1 || num_notas !== 6'd0) begin
            $display("FAIL rec_start ocupado=%b num=%0d exp 1/0", ocupado, num_notas);
            errors++;
        end
        key(0);
        checks++;
        if (leds !== 12'h001 || nota_out !== 4'd1) begin
            $display("FAIL rec_echo leds=%h nota=%0d exp 001/1", leds, nota_out);
            errors++;
        end
        beat();
        release_all();
        checks++;
        if (num_notas !== 6'd1 || endereco !== 5'd1) begin
            $display("FAIL rec_n1 num=%0d addr=%0d exp 1/1", num_notas, endereco);
            errors++;
        end
        key(4);
        beat();
        step();
        beat();
        release_all();
        key(7);
        beat();
        beat();
        beat();
        checks++;
        if (leds !== 12'h080 || nota_out !== 4'd8) begin
            $display("FAIL rec_echo3 leds=%h nota=%0d exp 080/8", leds, nota_out);
            errors++;
        end
        release_all();
        checks++;
        if (num_notas !== 6'd3 || endereco !== 5'd3 || ocupado !== 1'b1) begin
            $display("FAIL rec_n3 num=%0d addr=%0d ocupado=%b exp 3/3/1",
                     num_notas, endereco, ocupado);
            errors++;
        end
        stop();
        checks++;
        if (ocupado !== 1'b0 || num_notas !== 6'd3 || leds !== '0) begin
            $display("FAIL rec_stop ocupado=%b num=%0d leds=%h exp 0/3/0",
                     ocupado, num_notas, leds);
            errors++;
        end
    endtask

    task automatic test_playback();
        start(2'b10);
        checks++;
        if (toca !== 1'b0 || ocupado !== 1'b1 || nota_out !== 4'd0) begin
            $display("FAIL pb_read toca=%b ocupado=%b nota=%0d exp 0/1/0",
                     toca, ocupado, nota_out);
            errors++;
        end
        step();
        checks++;
        if (nota_out !== 4'd1 || leds !== 12'h001 || toca !== 1'b1) begin
            $display("FAIL pb_n0 nota=%0d leds=%h toca=%b exp 1/001/1", nota_out, leds, toca);
            errors++;
        end
        beat();
        checks++;
        if (toca !== 1'b0 || endereco !== 5'd1) begin
            $display("FAIL pb_adv1 toca=%b addr=%0d exp 0/1", toca, endereco);
            errors++;
        end
        step();
        checks++;
        if (nota_out !== 4'd5 || leds !== 12'h010) begin
            $display("FAIL pb_n1 nota=%0d leds=%h exp 5/010", nota_out, leds);
            errors++;
        end
        beat();
        step();
        checks++;
        if (nota_out !== 4'd5 || toca !== 1'b1) begin
            $display("FAIL pb_n1_hold nota=%0d toca=%b exp 5/1", nota_out, toca);
            errors++;
        end
        beat();
        checks++;
        if (endereco !== 5'd2 || toca !== 1'b0) begin
            $display("FAIL pb_adv2 addr=%0d toca=%b exp 2/0", endereco, toca);
            errors++;
        end
        step();
        beat();
        beat();
        checks++;
        if (nota_out !== 4'd8 || leds !== 12'h080) begin
            $display("FAIL pb_n2_hold nota=%0d leds=%h exp 8/080", nota_out, leds);
            errors++;
        end
        beat();
        checks++;
        if (fim !== 1'b1 || ocupado !== 1'b0 || toca !== 1'b0 || leds !== '0) begin
            $display("FAIL pb_end fim=%b ocupado=%b toca=%b leds=%h exp 1/0/0/0",
                     fim, ocupado, toca, leds);
            errors++;
        end
    endtask

    task automatic test_training();
        start(2'b11);
        step();
        checks++;
        if (nota_out !== 4'd1 || leds !== 12'h001 || toca !== 1'b0) begin
            $display("FAIL tr_show nota=%0d leds=%h toca=%b exp 1/001/0", nota_out, leds, toca);
            errors++;
        end
        key(0);
        checks++;
        if (acerto !== 1'b1 || erro !== 1'b0 || endereco !== 5'd1) begin
            $display("FAIL tr_hit acerto=%b erro=%b addr=%0d exp 1/0/1", acerto, erro, endereco);
            errors++;
        end
        release_all();
        checks++;
        if (acerto !== 1'b0 || nota_out !== 4'd5) begin
            $display("FAIL tr_pulse acerto=%b nota=%0d exp 0/5", acerto, nota_out);
            errors++;
        end
        key(3);
        checks++;
        if (erro !== 1'b1 || acerto !== 1'b0 || endereco !== 5'd1) begin
            $display("FAIL tr_miss erro=%b acerto=%b addr=%0d exp 1/0/1", erro, acerto, endereco);
            errors++;
        end
        release_all();
        checks++;
        if (erro !== 1'b0 || nota_out !== 4'd5 || ocupado !== 1'b1) begin
            $display("FAIL tr_stay erro=%b nota=%0d ocupado=%b exp 0/5/1", erro, nota_out, ocupado);
            errors++;
        end
        key(4);
        release_all();
        key(7);
        checks++;
        if (acerto !== 1'b1 || fim !== 1'b1) begin
            $display("FAIL tr_last acerto=%b fim=%b exp 1/1", acerto, fim);
            errors++;
        end
        release_all();
    endtask

    task automatic test_timeout();
        start(2'b11);
        step();
        repeat (7) beat();
        checks++;
        if (erro !== 1'b0 || ocupado !== 1'b1) begin
            $display("FAIL to_early erro=%b ocupado=%b exp 0/1", erro, ocupado);
            errors++;
        end
        beat();
        checks++;
        if (erro !== 1'b1 || fim !== 1'b1 || ocupado !== 1'b0) begin
            $display("FAIL to_fire erro=%b fim=%b ocupado=%b exp 1/1/0", erro, fim, ocupado);
            errors++;
        end
        step();
        checks++;
        if (erro !== 1'b0 || fim !== 1'b1) begin
            $display("FAIL to_pulse erro=%b fim=%b exp 0/1", erro, fim);
            errors++;
        end
    endtask

    task automatic test_saturation();
        start(2'b01);
        for (int i = 0; i < 32; i++) begin
            key(i % 12);
            repeat (20) beat();
            release_all();
            if (i == 30) begin
                checks++;
                if (num_notas !== 6'd31 || ocupado !== 1'b1) begin
                    $display("FAIL sat_n31 num=%0d ocupado=%b exp 31/1", num_notas, ocupado);
                    errors++;
                end
            end
        end
        checks++;
        if (num_notas !== 6'd32 || fim !== 1'b1 || ocupado !== 1'b0) begin
            $display("FAIL sat_full num=%0d fim=%b ocupado=%b exp 32/1/0", num_notas, fim, ocupado);
            errors++;
        end
        start(2'b10);
        step();
        repeat (14) beat();
        checks++;
        if (toca !== 1'b1 || nota_out !== 4'd1 || endereco !== 5'd0) begin
            $display("FAIL sat_hold toca=%b nota=%0d addr=%0d exp 1/1/0", toca, nota_out, endereco);
            errors++;
        end
        beat();
        checks++;
        if (toca !== 1'b0 || endereco !== 5'd1) begin
            $display("FAIL sat_dur15 toca=%b addr=%0d exp 0/1", toca, endereco);
            errors++;
        end
        stop();
        checks++;
        if (ocupado !== 1'b0 || num_notas !== 6'd32) begin
            $display("FAIL sat_stop ocupado=%b num=%0d exp 0/32", ocupado, num_notas);
            errors++;
        end
    endtask

    task automatic test_abort_reset();
        start(2'b01);
        key(1);
        beat();
        release_all();
        key(2);
        beat();
        release_all();
        key(3);
        beat();
        checks++;
        if (nota_out !== 4'd4 || leds !== 12'h008) begin
            $display("FAIL ab_echo nota=%0d leds=%h exp 4/008", nota_out, leds);
            errors++;
        end
        stop();
        checks++;
        if (ocupado !== 1'b0 || num_notas !== 6'd2 || leds !== '0) begin
            $display("FAIL ab_stop ocupado=%b num=%0d leds=%h exp 0/2/0", ocupado, num_notas, leds);
            errors++;
        end
        release_all();
        start(2'b10);
        step();
        checks++;
        if (nota_out !== 4'd2 || toca !== 1'b1) begin
            $display("FAIL ab_play nota=%0d toca=%b exp 2/1", nota_out, toca);
            errors++;
        end
        reset = 1'b0;
        #2;
        checks++;
        if (toca !== 1'b0 || num_notas !== 6'd0 || ocupado !== 1'b0 || leds !== '0) begin
            $display("FAIL ab_rst toca=%b num=%0d ocupado=%b leds=%h exp 0/0/0/0",
                     toca, num_notas, ocupado, leds);
            errors++;
        end
        step();
        reset = 1'b1;
        step();
        start(2'b10);
        checks++;
        if (fim !== 1'b1 || ocupado !== 1'b0) begin
            $display("FAIL ab_empty fim=%b ocupado=%b exp 1/0", fim, ocupado);
            errors++;
        end
    endtask

    initial begin
        reset = 1'b0;
        modo = 2'b00;
        iniciar = 1'b0;
        parar = 1'b0;
        pulso_metro = 1'b0;
        botoes = '0;
        test_reset();
        test_parar_priority();
        test_record();
        test_playback();
        test_training();
        test_timeout();
        test_saturation();
        test_abort_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
